dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
Shares the single burst DRAM port between the instruction-cache refill path and the data-cache refill/write-back path. Each client raises a level request with a burst-aligned word address. The arbiter grants one whole BURST_LEN-beat burst at a time, issues the command, and counts the beats. It steers read beats only to the granted client and sources write beats from the data side. Round-robin on ties; a burst is never pre-empted.

Parameters:
BURST_LEN, 8, beats per burst (power of two, ≥2); equals words per cache line
ADDR_W, 32, word-address width on client and DRAM sides
DATA_W, 32, beat width
CNT_W, 3, beat-counter width, log2(BURST_LEN)

Ports:
clock  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  I-side refill request, level, held until its burst completes
i_addr  in  ADDR_W  I-side burst start word address, low CNT_W bits zero
i_data  out  DATA_W  read beat data to I-side
i_valid  out  1  read beat strobe to I-side
d_req  in  1  D-side request, level
d_we  in  1  D-side direction: 1 = write-back, 0 = refill
d_addr  in  ADDR_W  D-side burst start word address
d_wdata  in  DATA_W  D-side current write beat
d_wready  out  1  D-side write beat accepted; advance to next word
d_rdata  out  DATA_W  read beat data to D-side
d_rvalid  out  1  read beat strobe to D-side
mem_cmd_valid  out  1  DRAM command valid
mem_cmd_ready  in  1  DRAM command accept
mem_cmd_we  out  1  DRAM command direction
mem_cmd_addr  out  ADDR_W  DRAM burst start address
mem_rdata  in  DATA_W  DRAM read beat
mem_rvalid  in  1  DRAM read beat strobe
mem_wdata  out  DATA_W  DRAM write beat
mem_wvalid  out  1  DRAM write beat valid
mem_wready  in  1  DRAM write beat accept
grant_i  out  1  burst owned by I-side
grant_d  out  1  burst owned by D-side
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, beat counter=0, last_grant=D (so the first tie goes to I)
  - all outputs 0: grant_*, mem_cmd_*, mem_wvalid, i_valid, d_rvalid, d_wready, err
  - any in-flight burst is abandoned; clients share rst.
- State machine IDLE -> CMD -> DATA -> RELEASE -> IDLE.
- IDLE:
  - One requester: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - On grant, register owner, address (i_addr, or d_addr) and we (0 for I, d_we for D); set grant_x; go to CMD.
  - Next state is CMD in the cycle after the request is seen, so one cycle of grant latency.
- CMD:
  - mem_cmd_valid=1, mem_cmd_addr/we come from registers.
  - On mem_cmd_ready, go to DATA with counter=0.
- DATA, read:
  - Each mem_rvalid is one beat. It is forwarded combinationally, with zero latency: i_valid or d_rvalid = mem_rvalid for the owner only; the other client's strobe stays 0.
  - i_data and d_rdata = mem_rdata at all times.
- DATA, write:
  - mem_wvalid=1, mem_wdata=d_wdata, d_wready=mem_wready.
  - A beat completes on mem_wvalid & mem_wready.
- Counter behaviour:
  - Increments per completed beat.
  - The beat that completes with counter=BURST_LEN-1 ends the burst: the counter wraps to 0, last_grant is updated to the owner, and the state goes to RELEASE.
- RELEASE:
  - Lasts exactly one cycle; grant_* is cleared and no requests are sampled.
  - This gives a level requester one cycle to drop its request after its final beat.
  - Then go to IDLE.
- Back-to-back behaviour:
  - If the same client still requests in IDLE while the other does not, it is granted again (no starvation penalty).
  - The minimum gap between bursts is RELEASE + IDLE = 2 cycles.
- Requests that change while the arbiter is not in IDLE are ignored until IDLE.
- err is set, and held until reset, on:
  - mem_rvalid outside DATA, or during a write burst
  - mem_wready while mem_wvalid=0
  - the offending beat is dropped and the counter is unchanged.
- A request dropped mid-burst does not abort the burst; the arbiter completes all BURST_LEN beats.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, CMD=1, DATA=2, RELEASE=3
  - owner encoding: OWN_I=0, OWN_D=1
  - BURST_LEN and CNT_W defaults, shared with both caches
- One natural sub-module: dram_rr_pick, a combinational two-way round-robin selector (i_req, d_req, last_grant -> grant_i_nxt, grant_d_nxt). Everything else stays in dram_arbiter.

Test Plan:
- I-only refill:
  - Stimulus: i_req=1, i_addr=0x100; mem_cmd_ready=1 in the first CMD cycle; 8 mem_rvalid beats 0xA0..0xA7.
  - Required: mem_cmd_addr=0x100, mem_cmd_we=0; exactly 8 i_valid with i_data 0xA0..0xA7; d_rvalid never 1; one RELEASE cycle, then IDLE.
- Simultaneous i_req and d_req (d_we=0, d_addr=0x208) out of reset:
  - Required: I is granted first; after its burst plus RELEASE, D is granted; mem_cmd_addr=0x208; d_rvalid pulses 8 times.
- D write-back:
  - Stimulus: d_we=1, d_addr=0x40; mem_wready toggled 1,0,1,1,0,1,1,1,1,1.
  - Required: 8 accepted beats; d_wready equals mem_wready during DATA; state returns to IDLE only after the 8th accept.
- Held I request after completion, with d_req=1 throughout:
  - Required: the next grant goes to D (round-robin), not I; the third grant goes back to I.
- Stray beats and mid-burst reset:
  - Stimulus: mem_rvalid pulsed in IDLE.
  - Required: err=1 and sticky; no client strobe.
  - Stimulus: rst=0 asserted in the middle of DATA at beat 3.
  - Required: all outputs 0 immediately (asynchronous), err=0, state IDLE.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM port arbiter and both cache refill paths.
package dram_arbiter_pkg;

  localparam int BURST_LEN_DEF = 8;
  localparam int CNT_W_DEF     = $clog2(BURST_LEN_DEF);
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Client and DRAM-side signal bundle of the arbiter.
// slave: the arbiter's view; master: the surrounding caches and DRAM controller.
interface dram_arbiter_if
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // I-side refill
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;

  // D-side refill / write-back
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;

  // DRAM port
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;

  // Status
  logic              grant_i;
  logic              grant_d;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_cmd_ready, mem_rdata, mem_rvalid, mem_wready,
    output i_data, i_valid, d_wready, d_rdata, d_rvalid,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid,
           grant_i, grant_d, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_cmd_ready, mem_rdata, mem_rvalid, mem_wready,
    input  i_data, i_valid, d_wready, d_rdata, d_rvalid,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata, mem_wvalid,
           grant_i, grant_d, err
  );

endinterface

// File: rtl/dram_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// client that did not own the previous burst.
module dram_rr_pick
  import dram_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   grant_i_nxt,
  output logic   grant_d_nxt
);

  // At most one of the two outputs is ever high.
  assign grant_i_nxt = i_req & (~d_req | (last_grant == OWN_D));
  assign grant_d_nxt = d_req & (~i_req | (last_grant == OWN_I));

endmodule

// File: rtl/dram_arbiter.sv
// Shares one burst DRAM port between the I-cache refill and D-cache
// refill/write-back paths. One whole burst is granted at a time and never
// pre-empted; read beats are steered to the owner with zero latency.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = $clog2(BURST_LEN)
)(
  input  logic           clock,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              grant_i_q;
  logic              grant_d_q;
  logic              cmd_valid_q;
  logic              wvalid_q;
  logic              err_q;

  logic              grant_i_nxt;
  logic              grant_d_nxt;
  logic              rd_burst;
  logic              beat_rd;
  logic              beat_wr;
  logic              beat_done;
  logic              stray_beat;
  logic              stray_wready;
  logic [DATA_W-1:0] rdata;

  dram_rr_pick u_pick (
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant),
    .grant_i_nxt (grant_i_nxt),
    .grant_d_nxt (grant_d_nxt)
  );

  // Beat qualification. A beat outside its legal window is dropped and flagged.
  assign rd_burst     = (state == DATA) && !we_q;
  assign beat_rd      = rd_burst & bus.mem_rvalid;
  assign beat_wr      = wvalid_q & bus.mem_wready;
  assign beat_done    = beat_rd | beat_wr;
  assign stray_beat   = bus.mem_rvalid & ~rd_burst;
  assign stray_wready = bus.mem_wready & ~wvalid_q;

  // Read data fans out to both clients; only the owner's strobe fires.
  assign rdata        = bus.mem_rdata;
  assign bus.i_data   = rdata;
  assign bus.d_rdata  = rdata;
  assign bus.i_valid  = beat_rd & (owner == OWN_I);
  assign bus.d_rvalid = beat_rd & (owner == OWN_D);

  // Write beats are always sourced from the D side.
  assign bus.mem_wdata  = bus.d_wdata;
  assign bus.mem_wvalid = wvalid_q;
  assign bus.d_wready   = beat_wr;

  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_we    = we_q;
  assign bus.mem_cmd_addr  = addr_q;
  assign bus.grant_i       = grant_i_q;
  assign bus.grant_d       = grant_d_q;
  assign bus.err           = err_q;

  // Burst sequencer: arbitrate, issue the command, count beats, release.
  // NOTE: every register here uses <= so all of them see the same pre-edge
  // values; a blocking assignment would let later lines observe new state.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      last_grant  <= OWN_D;
      cnt         <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      grant_i_q   <= 1'b0;
      grant_d_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      wvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (stray_beat || stray_wready) begin
        err_q <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (grant_i_nxt || grant_d_nxt) begin
            owner       <= grant_d_nxt ? OWN_D : OWN_I;
            addr_q      <= grant_d_nxt ? bus.d_addr : bus.i_addr;
            we_q        <= grant_d_nxt & bus.d_we;
            grant_i_q   <= grant_i_nxt;
            grant_d_q   <= grant_d_nxt;
            cmd_valid_q <= 1'b1;
            state       <= CMD;
          end
        end

        CMD: begin
          if (bus.mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wvalid_q    <= we_q;
            cnt         <= '0;
            state       <= DATA;
          end
        end

        DATA: begin
          if (beat_done) begin
            if (cnt == LAST_BEAT) begin
              cnt        <= '0;
              last_grant <= owner;
              wvalid_q   <= 1'b0;
              grant_i_q  <= 1'b0;
              grant_d_q  <= 1'b0;
              state      <= RELEASE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // One dead cycle lets a level requester drop after its final beat.
        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed sequences, an arbitration
// vector table, and a randomized run scored against a burst-level model.
module tb_dram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BL     = 8;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_arbiter #(
    .BURST_LEN (BL),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CNT_W     (3)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  typedef struct {
    bit prior_d;
    bit ireq;
    bit dreq;
    bit exp_gi;
    bit exp_gd;
  } arb_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req_i(input bit on, input logic [31:0] addr);
    bus.i_req  = on;
    bus.i_addr = addr;
  endtask

  task automatic req_d(input bit on, input bit we, input logic [31:0] addr);
    bus.d_req  = on;
    bus.d_we   = we;
    bus.d_addr = addr;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Waits (bounded) for a command; exp_lat > 0 also checks the cycle count.
  task automatic wait_cmd(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (bus.mem_cmd_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " cmd_valid"}, bus.mem_cmd_valid, 1'b1);
    if (exp_lat > 0) check({tag, " grant latency"}, lat, exp_lat);
  endtask

  // Plays DRAM plus the owning client for one burst, starting in CMD and
  // ending in the RELEASE cycle.
  task automatic serve(input bit own_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] seed, input bit rand_mode,
                       input logic [15:0] wpat, input string tag);
    int k;
    int cyc;
    bit gap;
    bit rdy;
    check({tag, " grant_i"}, bus.grant_i, !own_d);
    check({tag, " grant_d"}, bus.grant_d, own_d);
    check({tag, " cmd_addr"}, bus.mem_cmd_addr, addr);
    check({tag, " cmd_we"}, bus.mem_cmd_we, we);
    if (rand_mode) begin
      repeat ($urandom_range(0, 2)) tick();
    end
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    check({tag, " cmd_valid drop"}, bus.mem_cmd_valid, 1'b0);
    k   = 0;
    cyc = 0;
    if (!we) begin
      while (k < BL) begin
        gap = rand_mode && (cyc < 40) && ($urandom_range(0, 3) == 0);
        if (gap) begin
          bus.mem_rvalid = 1'b0;
          #1;
          check({tag, " idle strobes"}, {bus.i_valid, bus.d_rvalid}, 2'b00);
        end else begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = seed + k;
          #1;
          check({tag, " rd strobes"}, {bus.i_valid, bus.d_rvalid}, own_d ? 2'b01 : 2'b10);
          check({tag, " rd data"}, own_d ? bus.d_rdata : bus.i_data, seed + k);
          k++;
        end
        tick();
        cyc++;
      end
      bus.mem_rvalid = 1'b0;
    end else begin
      while (k < BL && cyc < 64) begin
        rdy = rand_mode ? 1'($urandom_range(0, 1)) : ((cyc < 16) ? wpat[cyc] : 1'b1);
        bus.mem_wready = rdy;
        bus.d_wdata    = seed + k;
        #1;
        check({tag, " wvalid"}, bus.mem_wvalid, 1'b1);
        check({tag, " d_wready"}, bus.d_wready, rdy);
        check({tag, " wdata"}, bus.mem_wdata, seed + k);
        tick();
        if (rdy) k++;
        cyc++;
      end
      bus.mem_wready = 1'b0;
    end
    check({tag, " release grants"}, {bus.grant_i, bus.grant_d}, 2'b00);
    check({tag, " release wvalid"}, bus.mem_wvalid, 1'b0);
  endtask

  arb_vec_t vecs[7];

  bit          pend_i, pend_d, we_d, last_d, exp_d;
  logic [31:0] addr_i, addr_d;

  initial begin
    vecs[0] = '{prior_d: 1'b0, ireq: 1'b1, dreq: 1'b0, exp_gi: 1'b1, exp_gd: 1'b0};
    vecs[1] = '{prior_d: 1'b0, ireq: 1'b0, dreq: 1'b1, exp_gi: 1'b0, exp_gd: 1'b1};
    vecs[2] = '{prior_d: 1'b0, ireq: 1'b1, dreq: 1'b1, exp_gi: 1'b0, exp_gd: 1'b1};
    vecs[3] = '{prior_d: 1'b1, ireq: 1'b1, dreq: 1'b1, exp_gi: 1'b1, exp_gd: 1'b0};
    vecs[4] = '{prior_d: 1'b1, ireq: 1'b1, dreq: 1'b0, exp_gi: 1'b1, exp_gd: 1'b0};
    vecs[5] = '{prior_d: 1'b1, ireq: 1'b0, dreq: 1'b1, exp_gi: 1'b0, exp_gd: 1'b1};
    vecs[6] = '{prior_d: 1'b1, ireq: 1'b0, dreq: 1'b0, exp_gi: 1'b0, exp_gd: 1'b0};

    req_i(1'b0, '0);
    req_d(1'b0, 1'b0, '0);
    bus.d_wdata       = '0;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rdata     = '0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_wready    = 1'b0;

    // Reset state
    tick();
    check("reset grants", {bus.grant_i, bus.grant_d}, 2'b00);
    check("reset cmd", {bus.mem_cmd_valid, bus.mem_cmd_we}, 2'b00);
    check("reset cmd_addr", bus.mem_cmd_addr, 32'h0);
    check("reset strobes", {bus.mem_wvalid, bus.i_valid, bus.d_rvalid, bus.d_wready}, 4'h0);
    check("reset err", bus.err, 1'b0);
    rst = 1'b1;
    tick();

    // I-only refill
    req_i(1'b1, 32'h100);
    wait_cmd(1, "ionly");
    serve(1'b0, 1'b0, 32'h100, 32'hA0, 1'b0, 16'hFFFF, "ionly");
    req_i(1'b0, '0);
    tick();
    check("ionly idle cmd", bus.mem_cmd_valid, 1'b0);
    tick();
    check("ionly stays idle", {bus.mem_cmd_valid, bus.grant_i, bus.grant_d}, 3'b000);

    // Simultaneous requests out of reset: I first, then D two cycles later
    do_reset();
    req_i(1'b1, 32'h300);
    req_d(1'b1, 1'b0, 32'h208);
    wait_cmd(1, "tie1");
    serve(1'b0, 1'b0, 32'h300, 32'h10, 1'b0, 16'hFFFF, "tie1");
    req_i(1'b0, '0);
    wait_cmd(2, "tie2");
    serve(1'b1, 1'b0, 32'h208, 32'h20, 1'b0, 16'hFFFF, "tie2");
    req_d(1'b0, 1'b0, '0);

    // D write-back with stalling mem_wready 1,0,1,1,0,1,1,1,1,1
    req_d(1'b1, 1'b1, 32'h40);
    wait_cmd(0, "wb");
    serve(1'b1, 1'b1, 32'h40, 32'hC0, 1'b0, 16'hFFED, "wb");
    req_d(1'b0, 1'b0, '0);

    // Held I request with D requesting throughout: I, D, I
    req_i(1'b1, 32'h500);
    req_d(1'b1, 1'b0, 32'h600);
    wait_cmd(2, "rr1");
    serve(1'b0, 1'b0, 32'h500, 32'h30, 1'b0, 16'hFFFF, "rr1");
    wait_cmd(2, "rr2");
    serve(1'b1, 1'b0, 32'h600, 32'h40, 1'b0, 16'hFFFF, "rr2");
    req_d(1'b0, 1'b0, '0);
    wait_cmd(2, "rr3");
    serve(1'b0, 1'b0, 32'h500, 32'h50, 1'b0, 16'hFFFF, "rr3");
    req_i(1'b0, '0);
    tick();
    tick();

    // Stray read beat in IDLE: flagged, sticky, never forwarded
    bus.mem_rvalid = 1'b1;
    #1;
    check("stray strobes", {bus.i_valid, bus.d_rvalid}, 2'b00);
    tick();
    bus.mem_rvalid = 1'b0;
    check("stray err", bus.err, 1'b1);
    tick();
    tick();
    check("stray err sticky", bus.err, 1'b1);

    // Asynchronous reset in the middle of beat 3 of an I refill
    req_i(1'b1, 32'h700);
    wait_cmd(0, "mid");
    bus.mem_cmd_ready = 1'b1;
    tick();
    bus.mem_cmd_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h70 + b;
      tick();
    end
    bus.mem_rdata = 32'h73;
    #1;
    check("mid beat3 i_valid", bus.i_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("mid reset grants", {bus.grant_i, bus.grant_d}, 2'b00);
    check("mid reset strobes", {bus.i_valid, bus.d_rvalid, bus.mem_cmd_valid, bus.mem_wvalid}, 4'h0);
    check("mid reset err", bus.err, 1'b0);
    bus.mem_rvalid = 1'b0;
    req_i(1'b0, '0);
    tick();
    rst = 1'b1;
    req_d(1'b1, 1'b0, 32'h780);
    wait_cmd(1, "post");
    serve(1'b1, 1'b0, 32'h780, 32'h80, 1'b0, 16'hFFFF, "post");
    req_d(1'b0, 1'b0, '0);
    check("post err", bus.err, 1'b0);
    tick();
    tick();

    // mem_wready without mem_wvalid is a protocol error too
    bus.mem_wready = 1'b1;
    tick();
    bus.mem_wready = 1'b0;
    check("stray wready err", bus.err, 1'b1);

    // Arbitration vector table
    do_reset();
    for (int r = 0; r < 7; r++) begin
      if (vecs[r].prior_d) req_d(1'b1, 1'b1, 32'h2000 + 32'(r) * 32);
      else                 req_i(1'b1, 32'h1000 + 32'(r) * 32);
      wait_cmd(0, "vec prior");
      serve(vecs[r].prior_d, vecs[r].prior_d, vecs[r].prior_d ? 32'h2000 + 32'(r) * 32 : 32'h1000 + 32'(r) * 32,
            32'h100 * r, 1'b0, 16'hFFFF, "vec prior");
      req_i(vecs[r].ireq, 32'h3000 + 32'(r) * 32);
      req_d(vecs[r].dreq, 1'b0, 32'h4000 + 32'(r) * 32);
      tick();
      tick();
      check($sformatf("vec%0d grants", r), {bus.grant_i, bus.grant_d}, {vecs[r].exp_gi, vecs[r].exp_gd});
      check($sformatf("vec%0d cmd_valid", r), bus.mem_cmd_valid, vecs[r].exp_gi | vecs[r].exp_gd);
      if (vecs[r].exp_gi | vecs[r].exp_gd) begin
        serve(vecs[r].exp_gd, 1'b0, vecs[r].exp_gd ? 32'h4000 + 32'(r) * 32 : 32'h3000 + 32'(r) * 32,
              32'h1000 * r, 1'b0, 16'hFFFF, $sformatf("vec%0d", r));
      end
      req_i(1'b0, '0);
      req_d(1'b0, 1'b0, '0);
      tick();
      tick();
    end

    // Randomized run against a burst-level round-robin model
    do_reset();
    pend_i = 0;
    pend_d = 0;
    last_d = 1;
    for (int n = 0; n < 40; n++) begin
      if (!pend_i && !pend_d) begin
        if ($urandom_range(0, 1) == 0) begin
          pend_i = 1; addr_i = $urandom & ~32'h7; req_i(1'b1, addr_i);
        end else begin
          pend_d = 1; addr_d = $urandom & ~32'h7; we_d = 1'($urandom_range(0, 1));
          req_d(1'b1, we_d, addr_d);
        end
      end
      exp_d = (pend_i && pend_d) ? !last_d : pend_d;
      wait_cmd(0, "rand");
      // Requests raised now are only seen at the next arbitration.
      if (exp_d && !pend_i && $urandom_range(0, 1) == 0) begin
        pend_i = 1; addr_i = $urandom & ~32'h7; req_i(1'b1, addr_i);
      end
      if (!exp_d && !pend_d && $urandom_range(0, 1) == 0) begin
        pend_d = 1; addr_d = $urandom & ~32'h7; we_d = 1'($urandom_range(0, 1));
        req_d(1'b1, we_d, addr_d);
      end
      serve(exp_d, exp_d & we_d, exp_d ? addr_d : addr_i, $urandom, 1'b1, 16'hFFFF,
            $sformatf("rand%0d", n));
      last_d = exp_d;
      if (exp_d) begin
        pend_d = 0; req_d(1'b0, 1'b0, '0);
        if ($urandom_range(0, 2) == 0) begin
          pend_d = 1; addr_d = $urandom & ~32'h7; we_d = 1'($urandom_range(0, 1));
          req_d(1'b1, we_d, addr_d);
        end
      end else begin
        pend_i = 0; req_i(1'b0, '0);
        if ($urandom_range(0, 2) == 0) begin
          pend_i = 1; addr_i = $urandom & ~32'h7; req_i(1'b1, addr_i);
        end
      end
    end
    check("rand err clean", bus.err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
